saph_raster_span: RTL

- Parametrised successor to the single-pixel primitive rasterizer.
- Scans a rectangle or triangle bounding box, clipped to a scissor window, and emits LANES horizontally adjacent pixels per beat with a coverage mask.
- Adds signed-area back-face culling and a completion pulse.
- Sits between primitive setup and the pixel shading/plot stage.

---
 rtl/saph_raster_span.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/saph_raster_span.sv
// rtl/saph_raster_span.sv - clipped rectangle/triangle span rasterizer emitting LANES-wide masked beats
module saph_raster_span #(
  parameter int COORD_W = 12,
  parameter int LANES   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_trig,
  input  logic [1:0]             in_type,
  input  logic [3*COORD_W-1:0]   in_x,
  input  logic [3*COORD_W-1:0]   in_y,
  input  logic                   cull_neg,
  input  logic [COORD_W-1:0]     scis_x0,
  input  logic [COORD_W-1:0]     scis_y0,
  input  logic [COORD_W-1:0]     scis_x1,
  input  logic [COORD_W-1:0]     scis_y1,
  output logic                   in_ready,
  output logic                   out_trig,
  output logic [COORD_W-1:0]     out_x,
  output logic [COORD_W-1:0]     out_y,
  output logic [LANES-1:0]       out_mask,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   done
);

  localparam int CW = COORD_W;
  localparam int EW = 2 * COORD_W + 2;  // edge / area arithmetic width
  localparam int XW = COORD_W + 1;      // coordinate width with headroom for x+LANES

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_SCAN, S_DONE} state_t;

  function automatic logic signed [EW-1:0] sx(input logic signed [CW-1:0] v);
    return {{(EW-CW){v[CW-1]}}, v};
  endfunction

  function automatic logic signed [XW-1:0] xw(input logic signed [CW-1:0] v);
    return {v[CW-1], v};
  endfunction

  state_t                state;
  logic [1:0]            typ_q;
  logic                  cull_neg_q;
  logic signed [CW-1:0]  vx_q [3];
  logic signed [CW-1:0]  vy_q [3];
  logic signed [CW-1:0]  sx0_q, sy0_q, sx1_q, sy1_q;
  logic signed [CW-1:0]  xmin_q, xmax_q, ymin_q, ymax_q;
  logic signed [CW-1:0]  x_q, y_q;
  logic                  area_neg_q;
  logic                  exhausted_q;
  logic signed [EW-1:0]  edx_q [3];
  logic signed [EW-1:0]  edy_q [3];

  logic signed [CW-1:0]  bx_lo, bx_hi, by_lo, by_hi;
  logic signed [CW-1:0]  cx_lo, cx_hi, cy_lo, cy_hi;
  logic signed [EW-1:0]  s_dx [3];
  logic signed [EW-1:0]  s_dy [3];
  logic signed [EW-1:0]  area;
  logic                  setup_cull;

  logic signed [EW-1:0]  e_acc [3];
  logic                  lane_in;
  logic [LANES-1:0]      lane_mask;

  logic signed [XW-1:0]  nx;
  logic                  wrap;
  logic                  ny_over;

  // Setup: bounding box, scissor clip, edge deltas, signed area and cull decision
  always_comb begin
    bx_lo = vx_q[0];
    bx_hi = vx_q[0];
    by_lo = vy_q[0];
    by_hi = vy_q[0];
    for (int k = 1; k < 3; k++) begin
      // a rectangle only spans v0/v1; v2 joins the box for triangles
      if (k == 1 || typ_q == 2'd1) begin
        if (vx_q[k] < bx_lo) bx_lo = vx_q[k];
        if (vx_q[k] > bx_hi) bx_hi = vx_q[k];
        if (vy_q[k] < by_lo) by_lo = vy_q[k];
        if (vy_q[k] > by_hi) by_hi = vy_q[k];
      end
    end
    cx_lo = (sx0_q > bx_lo) ? sx0_q : bx_lo;
    cx_hi = (sx1_q < bx_hi) ? sx1_q : bx_hi;
    cy_lo = (sy0_q > by_lo) ? sy0_q : by_lo;
    cy_hi = (sy1_q < by_hi) ? sy1_q : by_hi;
    for (int k = 0; k < 3; k++) begin
      s_dx[k] = sx(vx_q[(k + 1) % 3]) - sx(vx_q[k]);
      s_dy[k] = sx(vy_q[(k + 1) % 3]) - sx(vy_q[k]);
    end
    area = s_dx[0] * (sx(vy_q[2]) - sx(vy_q[0])) - s_dy[0] * (sx(vx_q[2]) - sx(vx_q[0]));
    setup_cull = (cx_lo > cx_hi) || (cy_lo > cy_hi) || typ_q[1] ||
                 ((typ_q == 2'd1) && ((area == '0) || (area[EW-1] && cull_neg_q)));
  end

  // Beat evaluation: per-lane coverage at (x_q, y_q); edge functions are stepped by -dy per lane.
  // Edges are oriented so the vertex opposite each edge evaluates to +A, hence interior pixels
  // share the sign of A.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      e_acc[k] = (sx(y_q) - sx(vy_q[k])) * edx_q[k] - (sx(x_q) - sx(vx_q[k])) * edy_q[k];
    end
    lane_mask = '0;
    lane_in   = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      lane_in = 1'b1;
      if (typ_q == 2'd1) begin
        for (int k = 0; k < 3; k++) begin
          if (area_neg_q ? (!e_acc[k][EW-1] && (e_acc[k] != '0)) : e_acc[k][EW-1]) lane_in = 1'b0;
        end
      end
      lane_mask[i] = lane_in && ((xw(x_q) + XW'(i)) <= xw(xmax_q));
      for (int k = 0; k < 3; k++) begin
        e_acc[k] = e_acc[k] - edy_q[k];
      end
    end
  end

  assign nx      = xw(x_q) + XW'(LANES);
  assign wrap    = nx > xw(xmax_q);
  assign ny_over = (xw(y_q) + XW'(1)) > xw(ymax_q);

  // Control FSM with registered handshake outputs and scan position
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      in_ready    <= 1'b1;
      out_trig    <= 1'b0;
      out_x       <= '0;
      out_y       <= '0;
      out_mask    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      typ_q       <= '0;
      cull_neg_q  <= 1'b0;
      sx0_q       <= '0;
      sy0_q       <= '0;
      sx1_q       <= '0;
      sy1_q       <= '0;
      xmin_q      <= '0;
      xmax_q      <= '0;
      ymin_q      <= '0;
      ymax_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      area_neg_q  <= 1'b0;
      exhausted_q <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        vx_q[k]  <= '0;
        vy_q[k]  <= '0;
        edx_q[k] <= '0;
        edy_q[k] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (in_trig) begin
            typ_q      <= in_type;
            cull_neg_q <= cull_neg;
            sx0_q      <= scis_x0;
            sy0_q      <= scis_y0;
            sx1_q      <= scis_x1;
            sy1_q      <= scis_y1;
            for (int k = 0; k < 3; k++) begin
              vx_q[k] <= in_x[k*CW +: CW];
              vy_q[k] <= in_y[k*CW +: CW];
            end
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          xmin_q      <= cx_lo;
          xmax_q      <= cx_hi;
          ymin_q      <= cy_lo;
          ymax_q      <= cy_hi;
          x_q         <= cx_lo;
          y_q         <= cy_lo;
          area_neg_q  <= area[EW-1];
          exhausted_q <= 1'b0;
          for (int k = 0; k < 3; k++) begin
            edx_q[k] <= s_dx[k];
            edy_q[k] <= s_dy[k];
          end
          if (setup_cull) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            state <= S_SCAN;
          end
        end
        S_SCAN: begin
          // a new beat may load when nothing is held or the held beat is being taken
          if (!out_trig || out_ready) begin
            if (exhausted_q) begin
              out_trig <= 1'b0;
              done     <= 1'b1;
              state    <= S_DONE;
            end else begin
              out_trig <= |lane_mask;
              out_x    <= x_q;
              out_y    <= y_q;
              out_mask <= lane_mask;
              if (wrap) begin
                x_q         <= xmin_q;
                y_q         <= y_q + CW'(1);
                exhausted_q <= ny_over;
              end else begin
                x_q <= nx[CW-1:0];
              end
            end
          end
        end
        default: begin
          in_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
